// File: rtl/day01_floor_stream.sv
// Streaming AoC 2015 day-1 floor solver (part 1 final floor, part 2 first TARGET_FLOOR position).
// Optional running floor extremes outputs are enabled with macro DAY01_EXTREMES_EN.
module day01_floor_stream #(
    parameter int                      PART         = 1,
    parameter int                      WIDTH        = 32,
    parameter int                      POS_WIDTH    = 32,
    parameter logic signed [WIDTH-1:0] TARGET_FLOOR = '1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              input_char,
    input  logic                    in_last,
    output logic signed [WIDTH-1:0] floor_out,
    output logic signed [WIDTH-1:0] result_out,
    output logic                    result_valid,
    output logic                    found,
`ifdef DAY01_EXTREMES_EN
    output logic signed [WIDTH-1:0] floor_min,
    output logic signed [WIDTH-1:0] floor_max,
`endif
    output logic                    overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [WIDTH-1:0] FLOOR_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] FLOOR_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                  state, state_nxt;
    logic [POS_WIDTH-1:0]    pos, pos_nxt;
    logic signed [WIDTH-1:0] floor_nxt;
    logic                    accept, is_up, is_down, is_paren;
    logic                    floor_wrap, pos_wrap, hit;

    // A step wraps when it leaves the two's-complement range in its direction.
    function automatic logic step_wraps(input logic signed [WIDTH-1:0] f,
                                        input logic up, input logic down);
        return (up && f == FLOOR_MAX) || (down && f == FLOOR_MIN);
    endfunction

    assign in_ready = (state != DONE) && !clear;
    assign accept   = in_valid && in_ready;
    assign is_up    = (input_char == 8'h28);
    assign is_down  = (input_char == 8'h29);
    assign is_paren = is_up || is_down;

    always_comb begin
        floor_nxt  = floor_out;
        pos_nxt    = pos;
        floor_wrap = step_wraps(floor_out, is_up, is_down);
        pos_wrap   = is_paren && (&pos);
        if (is_up) begin
            floor_nxt = floor_out + ONE;
        end else if (is_down) begin
            floor_nxt = floor_out - ONE;
        end
        if (is_paren) begin
            pos_nxt = pos + POS_WIDTH'(1);
        end
        hit = (PART == 2) && is_paren && !found && (floor_nxt == TARGET_FLOOR);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? DONE : RUN;
            RUN:     if (accept && in_last) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            floor_out    <= '0;
            pos          <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            found        <= 1'b0;
            overflow     <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            floor_out    <= '0;
            pos          <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            found        <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                floor_out <= floor_nxt;
                pos       <= pos_nxt;
                if (floor_wrap || pos_wrap) overflow <= 1'b1;
                // Part 2 answer freezes at the first hit; part 1 answer is the final floor.
                if (hit) begin
                    found      <= 1'b1;
                    result_out <= $signed(WIDTH'(pos_nxt));
                end
                if (in_last) begin
                    result_valid <= 1'b1;
                    if (PART == 1) result_out <= floor_nxt;
                end
            end
        end
    end

`ifdef DAY01_EXTREMES_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            floor_min <= '0;
            floor_max <= '0;
        end else if (clear) begin
            floor_min <= '0;
            floor_max <= '0;
        end else if (accept) begin
            if (floor_nxt < floor_min) floor_min <= floor_nxt;
            if (floor_nxt > floor_max) floor_max <= floor_nxt;
        end
    end
`endif

endmodule
